// File: rtl/uart_pkg.sv
// Shared UART constants and the transmit sequencer state type.
package uart_pkg;

    localparam int CLK_IN_HZ  = 50_000_000;
    localparam int BAUD_RATE  = 256_000;
    localparam int BIT_PERIOD = CLK_IN_HZ / BAUD_RATE;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE,
        SEND,
        WAIT_ACK,
        WAIT_DONE
    } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// Byte storage ring with registered occupancy count and full/empty flags.
module byte_fifo #(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  rd_en,
    output logic [DATA_W-1:0]     rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DEPTH_LOG2:0]   count_nxt;

    // Full is the registered flag, so a same-cycle pop never frees a slot for the write.
    assign wr_acc  = wr_en && !full;
    assign rd_acc  = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + 1'b1;
            2'b01:   count_nxt = count - 1'b1;
            default: count_nxt = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (wr_acc)
                wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == FULL_CNT);
            empty <= (count_nxt == '0);
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte FIFO plus send sequencer feeding rs232_uart_tx through send/tx_busy.
// Optional sticky overflow flag enabled by defining UART_TX_FIFO_OVF_EN.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4,
    parameter int DATA_W     = DATA_W_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  tx_send,
    output logic [DATA_W-1:0]     tx_data,
    input  logic                  tx_busy,
    output logic                  overflow
);

    tx_state_e         state;
    logic              pop;
    logic [DATA_W-1:0] head;

    assign pop = (state == IDLE) && !empty && !tx_busy;

    byte_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // tx_data is only loaded on a pop, so it holds until the UART has latched it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            tx_send <= 1'b0;
            tx_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data <= head;
                        tx_send <= 1'b1;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    tx_send <= 1'b0;
                    state   <= WAIT_ACK;
                end
                WAIT_ACK: begin
                    if (tx_busy)
                        state <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (!tx_busy)
                        state <= IDLE;
                end
                default: begin
                    tx_send <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

`ifdef UART_TX_FIFO_OVF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            overflow <= 1'b0;
        else if (wr_en && full)
            overflow <= 1'b1;
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a behavioural UART busy model.
module tb_uart_tx_fifo;
    import uart_pkg::*;

`ifdef UART_TX_FIFO_OVF_EN
    localparam logic OVF_EXP = 1'b1;
`else
    localparam logic OVF_EXP = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       tx_send;
    logic [7:0] tx_data;
    logic       tx_busy;
    logic       overflow;

    logic       ubusy = 1'b0;
    int         ucnt = 0;
    int         busy_len;
    logic       hold_busy;
    logic [7:0] sent_q[$];
    int         busy_viol = 0;

    int n_tests = 0;
    int n_fail  = 0;
    int peak    = 0;

    assign tx_busy = ubusy | hold_busy;

    uart_tx_fifo #(
        .DEPTH_LOG2 (4),
        .DATA_W     (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .full     (full),
        .empty    (empty),
        .count    (count),
        .tx_send  (tx_send),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .overflow (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #10 clk = ~clk;
    end

    // UART model: busy rises the cycle after a send pulse and stays up busy_len cycles.
    always @(posedge clk) begin
        if (tx_send) begin
            sent_q.push_back(tx_data);
            if (tx_busy)
                busy_viol <= busy_viol + 1;
        end
        if (tx_send && !ubusy) begin
            ubusy <= 1'b1;
            ucnt  <= busy_len;
        end else if (ubusy) begin
            if (ucnt <= 1)
                ubusy <= 1'b0;
            ucnt <= ucnt - 1;
        end
    end

    task automatic tick();
        @(negedge clk);
        if (int'(count) > peak)
            peak = int'(count);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic write_byte(input logic [7:0] b);
        wr_en   = 1'b1;
        wr_data = b;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_drain(input string tag, input int target, input int bound);
        int  k;
        logic done;
        k = 0;
        done = 1'b0;
        while (!done && k < bound) begin
            done = (sent_q.size() >= target) && !tx_busy && empty && (dut.state == IDLE);
            if (!done) begin
                tick();
                k++;
            end
        end
        check(tag, 32'(done), 32'd1);
        tick();
        tick();
    endtask

    initial begin
        int base;
        int k;
        logic seen;

        rst       = 1'b1;
        wr_en     = 1'b0;
        wr_data   = 8'h00;
        hold_busy = 1'b0;
        busy_len  = 2000;
        tick();
        tick();

        // Reset state
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_tx_send", 32'(tx_send), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'h00);
        check("rst_overflow", 32'(overflow), 32'd0);
        rst = 1'b0;
        tick();

        // Test 1: single byte, latency and long busy
        write_byte(8'hA5);
        check("t1_empty_after_wr", 32'(empty), 32'd0);
        check("t1_count_after_wr", 32'(count), 32'd1);
        check("t1_no_send_yet", 32'(tx_send), 32'd0);
        tick();
        check("t1_send_pulse", 32'(tx_send), 32'd1);
        check("t1_tx_data", 32'(tx_data), 32'hA5);
        check("t1_count_after_pop", 32'(count), 32'd0);
        tick();
        check("t1_send_one_cycle", 32'(tx_send), 32'd0);
        wait_drain("t1_drain", 1, 2200);
        check("t1_send_count", 32'(sent_q.size()), 32'd1);
        check("t1_byte", 32'(sent_q[0]), 32'hA5);
        check("t1_count_end", 32'(count), 32'd0);
        check("t1_empty_end", 32'(empty), 32'd1);

        // Test 2: burst of three, first pop overlaps the second write
        busy_len = 10;
        base = sent_q.size();
        peak = 0;
        write_byte(8'h11);
        write_byte(8'h22);
        write_byte(8'h33);
        tick();
        check("t2_peak", 32'(peak), 32'd2);
        wait_drain("t2_drain", base + 3, 500);
        check("t2_sends", 32'(sent_q.size() - base), 32'd3);
        check("t2_b0", 32'(sent_q[base]), 32'h11);
        check("t2_b1", 32'(sent_q[base + 1]), 32'h22);
        check("t2_b2", 32'(sent_q[base + 2]), 32'h33);
        check("t2_busy_viol", 32'(busy_viol), 32'd0);

        // Test 3: fill with line held busy, 17th byte dropped
        hold_busy = 1'b1;
        base = sent_q.size();
        for (int i = 0; i < 16; i++)
            write_byte(8'(i));
        check("t3_full", 32'(full), 32'd1);
        check("t3_count16", 32'(count), 32'd16);
        check("t3_ovf_before", 32'(overflow), 32'd0);
        write_byte(8'h10);
        check("t3_count_drop", 32'(count), 32'd16);
        check("t3_full_hold", 32'(full), 32'd1);
        check("t3_overflow", 32'(overflow), 32'(OVF_EXP));
        check("t3_no_send", 32'(sent_q.size() - base), 32'd0);
        hold_busy = 1'b0;
        wait_drain("t3_drain", base + 16, 2000);
        check("t3_sends", 32'(sent_q.size() - base), 32'd16);
        for (int i = 0; i < 16; i++)
            check($sformatf("t3_byte%0d", i), 32'(sent_q[base + i]), 32'(i));

        // Test 4: write at full coincident with a pop is rejected
        hold_busy = 1'b1;
        base = sent_q.size();
        for (int i = 0; i < 16; i++)
            write_byte(8'h40 + 8'(i));
        check("t4_full", 32'(full), 32'd1);
        hold_busy = 1'b0;
        write_byte(8'hEE);
        check("t4_count15", 32'(count), 32'd15);
        check("t4_not_full", 32'(full), 32'd0);
        wait_drain("t4_drain", base + 16, 2000);
        check("t4_sends", 32'(sent_q.size() - base), 32'd16);
        for (int i = 0; i < 16; i++)
            check($sformatf("t4_byte%0d", i), 32'(sent_q[base + i]), 32'h40 + 32'(i));

        // Test 5: reset during WAIT_DONE with five bytes queued
        busy_len = 50;
        for (int i = 0; i < 6; i++)
            write_byte(8'h60 + 8'(i));
        k = 0;
        while (!tx_busy && k < 20) begin
            tick();
            k++;
        end
        check("t5_busy_seen", 32'(tx_busy), 32'd1);
        tick();
        tick();
        check("t5_state_wait_done", 32'(dut.state), 32'(WAIT_DONE));
        check("t5_count5", 32'(count), 32'd5);
        rst = 1'b1;
        #1;
        check("t5_rst_state", 32'(dut.state), 32'(IDLE));
        check("t5_rst_count", 32'(count), 32'd0);
        check("t5_rst_empty", 32'(empty), 32'd1);
        check("t5_rst_tx_send", 32'(tx_send), 32'd0);
        check("t5_rst_tx_data", 32'(tx_data), 32'h00);
        check("t5_rst_overflow", 32'(overflow), 32'd0);
        tick();
        rst = 1'b0;
        base = sent_q.size();
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (tx_send)
                seen = 1'b1;
        end
        check("t5_no_send_after_rst", 32'(seen), 32'd0);
        check("t5_no_log_after_rst", 32'(sent_q.size() - base), 32'd0);
        write_byte(8'h77);
        wait_drain("t5_drain", base + 1, 300);
        check("t5_new_byte", 32'(sent_q[base]), 32'h77);

        // Test 6: stream 24 bytes through the pointer wrap
        busy_len = 3;
        base = sent_q.size();
        peak = 0;
        for (int i = 0; i < 24; i++) begin
            k = 0;
            while (full && k < 100) begin
                tick();
                k++;
            end
            write_byte(8'h80 + 8'(i));
        end
        wait_drain("t6_drain", base + 24, 1000);
        check("t6_peak_le_16", 32'(peak <= 16), 32'd1);
        check("t6_sends", 32'(sent_q.size() - base), 32'd24);
        for (int i = 0; i < 24; i++)
            check($sformatf("t6_byte%0d", i), 32'(sent_q[base + i]), 32'h80 + 32'(i));
        check("t6_overflow", 32'(overflow), 32'd0);
        check("t6_busy_viol", 32'(busy_viol), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
